// File: rtl/mips32_pkg.sv
// Shared MIPS32 core types: memory arbiter state/owner encodings and load/store opcodes.
package mips32_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } arb_owner_e;

    localparam logic [5:0] OP_LW = 6'h23;
    localparam logic [5:0] OP_SW = 6'h2B;

endpackage

// File: rtl/mips32_mem_arbiter.sv
// Arbitrates the unified single-ported memory between instruction fetch and load/store,
// data first, with fetch promoted after STARVE_MAX consecutive denied cycles.
module mips32_mem_arbiter
    import mips32_pkg::*;
#(
    parameter int unsigned AW         = 10,
    parameter int unsigned DW         = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk1,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int unsigned LAT_W = $clog2(MEM_LAT + 1);
    localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

    arb_state_e       state;
    arb_owner_e       owner;
    logic [LAT_W-1:0] lat_cnt;
    logic [STV_W-1:0] starve_cnt;

    logic lat_done;
    logic grant_win;
    logic fetch_pri;
    logic sel_d;
    logic sel_f;
    logic rd_grant;

    // Grant decode from registered state and live requests; final latency cycle is a grant window.
    always_comb begin
        lat_done  = 1'b0;
        grant_win = 1'b0;
        fetch_pri = 1'b0;
        sel_d     = 1'b0;
        sel_f     = 1'b0;
        rd_grant  = 1'b0;
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
        busy      = 1'b0;

        lat_done  = (state == ARB_WAIT) && (lat_cnt == LAT_W'(MEM_LAT));
        grant_win = rst_n && ((state == ARB_IDLE) || lat_done);
        fetch_pri = if_req && (starve_cnt == STV_W'(STARVE_MAX));
        sel_d     = grant_win && d_req && !fetch_pri;
        sel_f     = grant_win && if_req && !sel_d;
        rd_grant  = sel_f || (sel_d && !d_we);

        if_gnt    = sel_f;
        d_gnt     = sel_d;
        mem_en    = sel_d || sel_f;
        mem_we    = sel_d && d_we;
        if (sel_d) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (sel_f) begin
            mem_addr  = if_addr;
        end

        if_rvalid = lat_done && (owner == OWN_FETCH);
        d_rvalid  = lat_done && (owner == OWN_DATA);
        busy      = (state == ARB_WAIT) && !lat_done;
    end

    assign if_rdata = mem_rdata;
    assign d_rdata  = mem_rdata;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            owner      <= OWN_FETCH;
            lat_cnt    <= '0;
            starve_cnt <= '0;
        end else begin
            if (rd_grant) begin
                state   <= ARB_WAIT;
                owner   <= sel_d ? OWN_DATA : OWN_FETCH;
                lat_cnt <= LAT_W'(1);
            end else if ((state == ARB_WAIT) && !lat_done) begin
                lat_cnt <= lat_cnt + LAT_W'(1);
            end else begin
                state   <= ARB_IDLE;
                lat_cnt <= '0;
            end

            // Count only cycles where fetch waits; saturate so promotion persists.
            if (if_req && !sel_f) begin
                if (starve_cnt != STV_W'(STARVE_MAX))
                    starve_cnt <= starve_cnt + STV_W'(1);
            end else begin
                starve_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Directed bench for mips32_mem_arbiter: MEM_LAT=1 and MEM_LAT=3 instances with memory models
// and a read-data scoreboard.
module tb_mips32_mem_arbiter;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
    } sb_t;

    logic clk1;
    logic rst1_n, rst3_n;
    logic if_req, d_req, d_we;
    logic [9:0]  if_addr, d_addr;
    logic [31:0] d_wdata;

    logic        if_gnt1, if_rvalid1, d_gnt1, d_rvalid1, mem_en1, mem_we1, busy1;
    logic [31:0] if_rdata1, d_rdata1, mem_wdata1, mem_rdata1;
    logic [9:0]  mem_addr1;
    logic        if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, mem_en3, mem_we3, busy3;
    logic [31:0] if_rdata3, d_rdata3, mem_wdata3, mem_rdata3;
    logic [9:0]  mem_addr3;

    logic [31:0] mem1 [1024];
    logic [31:0] mem3 [1024];
    logic [31:0] p1;
    logic [31:0] p3 [3];

    sb_t q[2][$];
    int  checks = 0;
    int  errors = 0;
    bit  stored12 = 1'b0;

    mips32_mem_arbiter #(.AW(10), .DW(32), .MEM_LAT(1), .STARVE_MAX(4)) u1 (
        .clk1(clk1), .rst_n(rst1_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt1), .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1), .busy(busy1)
    );

    mips32_mem_arbiter #(.AW(10), .DW(32), .MEM_LAT(3), .STARVE_MAX(4)) u3 (
        .clk1(clk1), .rst_n(rst3_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
        .mem_rdata(mem_rdata3), .busy(busy3)
    );

    function automatic logic [31:0] pat(input logic [9:0] a);
        return 32'hC0DE0000 + 32'(a) * 32'd3;
    endfunction

    function automatic logic [31:0] exp_word(input logic [9:0] a);
        return (stored12 && a == 10'd12) ? 32'hDEADBEEF : pat(a);
    endfunction

    initial begin
        clk1 = 1'b0;
        forever #5 clk1 = ~clk1;
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem1[i] <= pat(10'(i));
            mem3[i] <= pat(10'(i));
        end
    end

    // Memory models: one-cycle and three-cycle read pipelines.
    always @(posedge clk1) begin
        if (mem_en1 && mem_we1) mem1[mem_addr1] <= mem_wdata1;
        p1 <= (mem_en1 && !mem_we1) ? mem1[mem_addr1] : 32'hxxxxxxxx;
        if (mem_en3 && mem_we3) mem3[mem_addr3] <= mem_wdata3;
        p3[0] <= (mem_en3 && !mem_we3) ? mem3[mem_addr3] : 32'hxxxxxxxx;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign mem_rdata1 = p1;
    assign mem_rdata3 = p3[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic mon_port(input int k, input logic port, input logic rv, input logic [31:0] rd);
        sb_t e;
        if (rv) begin
            if (q[k].size() == 0) begin
                check("rvalid_without_read", 32'(rv), 32'd0);
            end else begin
                e = q[k].pop_front();
                check("rvalid_port", 32'(port), 32'(e.port));
                check("rdata", rd, e.data);
            end
        end
    endtask

    task automatic mon_push(input int k, input logic ig, input logic dg);
        if (ig) q[k].push_back('{port: 1'b0, data: exp_word(if_addr)});
        if (dg && !d_we) q[k].push_back('{port: 1'b1, data: exp_word(d_addr)});
    endtask

    // Mid-cycle sample point: retire rvalids, then record new read grants.
    task automatic mid();
        @(negedge clk1);
        mon_port(0, 1'b0, if_rvalid1, if_rdata1);
        mon_port(0, 1'b1, d_rvalid1, d_rdata1);
        mon_port(1, 1'b0, if_rvalid3, if_rdata3);
        mon_port(1, 1'b1, d_rvalid3, d_rdata3);
        mon_push(0, if_gnt1, d_gnt1);
        mon_push(1, if_gnt3, d_gnt3);
    endtask

    task automatic nxt();
        @(posedge clk1);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            mid();
            nxt();
        end
    endtask

    initial begin
        rst1_n = 1'b0; rst3_n = 1'b0;
        if_req = 1'b1; if_addr = 10'd3;
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'd4; d_wdata = 32'd0;

        mid();
        check("reset_outs_u1", 32'({if_gnt1, d_gnt1, mem_en1, mem_we1, busy1, if_rvalid1, d_rvalid1}), 32'd0);
        check("reset_outs_u3", 32'({if_gnt3, d_gnt3, mem_en3, mem_we3, busy3, if_rvalid3, d_rvalid3}), 32'd0);
        nxt();
        if_req = 1'b0; d_req = 1'b0;
        rst1_n = 1'b1;
        run(1);

        // Streaming fetch, one grant per cycle
        if_req = 1'b1;
        for (int n = 0; n < 8; n++) begin
            if_addr = 10'(n);
            mid();
            check("stream_if_gnt", 32'(if_gnt1), 32'd1);
            check("stream_mem_addr", 32'(mem_addr1), 32'(n));
            nxt();
        end
        if_req = 1'b0;
        run(1);

        // Same-cycle fetch and load: data first
        if_req = 1'b1; if_addr = 10'd5;
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'd20;
        mid();
        check("prio_d_gnt", 32'(d_gnt1), 32'd1);
        check("prio_if_gnt", 32'(if_gnt1), 32'd0);
        nxt();
        d_req = 1'b0;
        mid();
        check("prio_d_rvalid", 32'(d_rvalid1), 32'd1);
        check("prio_if_gnt_next", 32'(if_gnt1), 32'd1);
        nxt();
        if_req = 1'b0;
        run(1);

        // Fetch starvation promotion under continuous loads
        if_req = 1'b1; if_addr = 10'd6;
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'd30;
        for (int i = 0; i < 10; i++) begin
            mid();
            check("starve_if_gnt", 32'(if_gnt1), 32'((i == 4) || (i == 9)));
            check("starve_d_gnt", 32'(d_gnt1), 32'(!((i == 4) || (i == 9))));
            nxt();
        end
        if_req = 1'b0; d_req = 1'b0;
        run(2);

        // Store then load back
        d_req = 1'b1; d_we = 1'b1; d_addr = 10'd12; d_wdata = 32'hDEADBEEF;
        mid();
        check("store_gnt", 32'(d_gnt1), 32'd1);
        check("store_mem_we", 32'(mem_we1), 32'd1);
        check("store_mem_addr", 32'(mem_addr1), 32'd12);
        check("store_mem_wdata", mem_wdata1, 32'hDEADBEEF);
        nxt();
        d_req = 1'b0; d_we = 1'b0; stored12 = 1'b1;
        mid();
        check("store_we_one_cycle", 32'(mem_we1), 32'd0);
        check("store_no_rvalid", 32'(d_rvalid1), 32'd0);
        nxt();
        d_req = 1'b1;
        mid();
        check("load12_gnt", 32'(d_gnt1), 32'd1);
        nxt();
        d_req = 1'b0;
        run(1);

        // Switch to the MEM_LAT=3 instance
        rst1_n = 1'b0; rst3_n = 1'b1;
        run(1);

        d_req = 1'b1; d_we = 1'b0; d_addr = 10'd9;
        mid();
        check("lat3_d_gnt", 32'(d_gnt3), 32'd1);
        check("lat3_busy_t", 32'(busy3), 32'd0);
        nxt();
        d_req = 1'b0; if_req = 1'b1; if_addr = 10'd2;
        for (int i = 1; i <= 2; i++) begin
            mid();
            check("lat3_busy", 32'(busy3), 32'd1);
            check("lat3_if_blocked", 32'(if_gnt3), 32'd0);
            check("lat3_no_rvalid", 32'(d_rvalid3), 32'd0);
            nxt();
        end
        mid();
        check("lat3_d_rvalid_t3", 32'(d_rvalid3), 32'd1);
        check("lat3_if_gnt_t3", 32'(if_gnt3), 32'd1);
        check("lat3_busy_t3", 32'(busy3), 32'd0);
        nxt();
        if_req = 1'b0;
        mid();
        check("lat3_fetch_busy", 32'(busy3), 32'd1);
        nxt();
        run(2);

        // Reset with a read outstanding
        d_req = 1'b1; d_addr = 10'd40;
        mid();
        check("rst_read_gnt", 32'(d_gnt3), 32'd1);
        nxt();
        d_req = 1'b0;
        check("rst_busy_before", 32'(busy3), 32'd1);
        rst3_n = 1'b0;
        q[1].delete();
        #1;
        check("rst_async_outs", 32'({if_gnt3, d_gnt3, mem_en3, mem_we3, busy3, if_rvalid3, d_rvalid3}), 32'd0);
        run(2);
        rst3_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            mid();
            check("rst_no_rvalid", 32'({if_rvalid3, d_rvalid3}), 32'd0);
            nxt();
        end

        check("sb_empty", 32'(q[0].size() + q[1].size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
